// File: rtl/alarm_time_controller.sv
// Clock-digit sequencer: seconds counting, 23:59 rollover and button-driven time setting.
// Optional build macro SET_BLINK_EN adds a per-Tick blink of the selected digit in set mode.
module alarm_time_controller #(
    parameter int SEC_PER_MIN = 60
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       Tick,
    input  logic       BtnMode,
    input  logic       BtnInc,
    input  logic [1:0] HT,
    input  logic [3:0] HU,
    input  logic [2:0] MT,
    input  logic [3:0] MU,
    output logic [3:0] Inc,
    output logic [3:0] Ld,
    output logic [2:0] Mode,
    output logic [3:0] Blank
);

    localparam int SCW = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_HT = 3'd1,
        SET_HU = 3'd2,
        SET_MT = 3'd3,
        SET_MU = 3'd4
    } mode_e;

    mode_e          mode_q, mode_d;
    logic [SCW-1:0] sc_q, sc_d;
    logic [3:0]     inc_q, inc_d;
    logic [3:0]     ld_q, ld_d;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            mode_q <= RUN;
            sc_q   <= '0;
            inc_q  <= '0;
            ld_q   <= '0;
        end else begin
            mode_q <= mode_d;
            sc_q   <= sc_d;
            inc_q  <= inc_d;
            ld_q   <= ld_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        sc_d   = sc_q;
        inc_d  = '0;
        ld_d   = '0;
        unique case (mode_q)
            RUN: begin
                // A mode press takes priority over a coincident Tick
                if (BtnMode) begin
                    mode_d = SET_HT;
                end else if (Tick) begin
                    if (sc_q == SCW'(SEC_PER_MIN - 1)) begin
                        sc_d = '0;
                        if (MU != 4'd9) begin
                            inc_d[0] = 1'b1;
                        end else begin
                            ld_d[0] = 1'b1;
                            if (MT != 3'd5) begin
                                inc_d[1] = 1'b1;
                            end else begin
                                ld_d[1] = 1'b1;
                                if (HT == 2'd2 && HU == 4'd3) begin
                                    ld_d[3:2] = 2'b11;
                                end else if (HU == 4'd9) begin
                                    ld_d[2]  = 1'b1;
                                    inc_d[3] = 1'b1;
                                end else begin
                                    inc_d[2] = 1'b1;
                                end
                            end
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            SET_HT: begin
                if (BtnMode) begin
                    mode_d = SET_HU;
                    // Hours 24..29 are illegal, so pull the units back to zero
                    if (HT == 2'd2 && HU > 4'd3) ld_d[2] = 1'b1;
                end else if (BtnInc) begin
                    if (HT >= 2'd2) ld_d[3] = 1'b1;
                    else            inc_d[3] = 1'b1;
                end
            end
            SET_HU: begin
                if (BtnMode) begin
                    mode_d = SET_MT;
                end else if (BtnInc) begin
                    if (HU >= ((HT == 2'd2) ? 4'd3 : 4'd9)) ld_d[2] = 1'b1;
                    else                                     inc_d[2] = 1'b1;
                end
            end
            SET_MT: begin
                if (BtnMode) begin
                    mode_d = SET_MU;
                end else if (BtnInc) begin
                    if (MT >= 3'd5) ld_d[1] = 1'b1;
                    else            inc_d[1] = 1'b1;
                end
            end
            SET_MU: begin
                if (BtnMode) begin
                    mode_d = RUN;
                    sc_d   = '0;
                end else if (BtnInc) begin
                    if (MU >= 4'd9) ld_d[0] = 1'b1;
                    else            inc_d[0] = 1'b1;
                end
            end
            default: mode_d = RUN;
        endcase
    end

    assign Inc  = inc_q;
    assign Ld   = ld_q;
    assign Mode = mode_q;

`ifdef SET_BLINK_EN
    logic blink_q, blink_d;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) blink_q <= 1'b0;
        else     blink_q <= blink_d;
    end

    always_comb begin
        blink_d = blink_q;
        if (mode_q != RUN && Tick) blink_d = ~blink_q;
        if (mode_d == RUN)         blink_d = 1'b0;
    end

    always_comb begin
        Blank = 4'b0000;
        unique case (mode_q)
            SET_HT:  Blank[3] = blink_q;
            SET_HU:  Blank[2] = blink_q;
            SET_MT:  Blank[1] = blink_q;
            SET_MU:  Blank[0] = blink_q;
            default: Blank = 4'b0000;
        endcase
    end
`else
    assign Blank = 4'b0000;
`endif

endmodule

// File: tb/tb_alarm_time_controller.sv
// Bench for alarm_time_controller: digit counter bank, hh:mm arithmetic model and directed stimulus.
module tb_alarm_time_controller;

    localparam int SPM = 4;

    logic       Clk = 1'b0;
    logic       Clr = 1'b0;
    logic       Tick = 1'b0, BtnMode = 1'b0, BtnInc = 1'b0;
    logic [1:0] bHT = '0;
    logic [3:0] bHU = '0;
    logic [2:0] bMT = '0;
    logic [3:0] bMU = '0;
    logic [3:0] Inc, Ld, Blank;
    logic [2:0] Mode;

    int checks = 0;
    int failures = 0;

    // bank load request
    logic load_en = 1'b0;
    int   ld_ht, ld_hu, ld_mt, ld_mu;

    // model state
    int         hh = 0, mm = 0, m_mode = 0, m_sc = 0, t;
    bit         m_blink = 1'b0;
    logic [3:0] e_inc = '0, e_ld = '0;
    int         od[4], nd[4];
    int         lim, u;

    alarm_time_controller #(.SEC_PER_MIN(SPM)) dut (
        .Clk(Clk), .Clr(Clr), .Tick(Tick), .BtnMode(BtnMode), .BtnInc(BtnInc),
        .HT(bHT), .HU(bHU), .MT(bMT), .MU(bMU),
        .Inc(Inc), .Ld(Ld), .Mode(Mode), .Blank(Blank)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Digit counter bank: Enable=Inc|Ld, Up=Inc, LD=Ld with zero load value
    always @(posedge Clk) begin
        if (load_en) begin
            bHT <= 2'(ld_ht); bHU <= 4'(ld_hu); bMT <= 3'(ld_mt); bMU <= 4'(ld_mu);
        end else begin
            if (Ld[3]) bHT <= '0; else if (Inc[3]) bHT <= bHT + 1'b1;
            if (Ld[2]) bHU <= '0; else if (Inc[2]) bHU <= bHU + 1'b1;
            if (Ld[1]) bMT <= '0; else if (Inc[1]) bMT <= bMT + 1'b1;
            if (Ld[0]) bMU <= '0; else if (Inc[0]) bMU <= bMU + 1'b1;
        end
    end

    // Model: track time as hh/mm integers; strobes are the digit differences
    always @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            m_mode = 0; m_sc = 0; m_blink = 1'b0; e_inc = '0; e_ld = '0;
        end else if (load_en) begin
            hh = ld_ht * 10 + ld_hu; mm = ld_mt * 10 + ld_mu; e_inc = '0; e_ld = '0;
        end else begin
            od[3] = hh / 10; od[2] = hh % 10; od[1] = mm / 10; od[0] = mm % 10;
            e_inc = '0; e_ld = '0;
            if (m_mode == 0) begin
                if (BtnMode) m_mode = 1;
                else if (Tick) begin
                    m_sc = m_sc + 1;
                    if (m_sc == SPM) begin
                        m_sc = 0;
                        t = (hh * 60 + mm + 1) % 1440;
                        hh = t / 60; mm = t % 60;
                    end
                end
            end else begin
                if (Tick) m_blink = !m_blink;
                if (BtnMode) begin
                    if (m_mode == 1 && hh / 10 == 2 && hh % 10 > 3) hh = 20;
                    m_mode = (m_mode + 1) % 5;
                    if (m_mode == 0) begin m_sc = 0; m_blink = 1'b0; end
                end else if (BtnInc) begin
                    case (m_mode)
                        1: hh = ((hh / 10 == 2) ? 0 : hh / 10 + 1) * 10 + hh % 10;
                        2: begin
                            lim = (hh / 10 == 2) ? 3 : 9; u = hh % 10;
                            hh = (hh / 10) * 10 + ((u >= lim) ? 0 : u + 1);
                        end
                        3: mm = ((mm / 10 == 5) ? 0 : mm / 10 + 1) * 10 + mm % 10;
                        default: mm = (mm / 10) * 10 + ((mm % 10 == 9) ? 0 : mm % 10 + 1);
                    endcase
                end
            end
            nd[3] = hh / 10; nd[2] = hh % 10; nd[1] = mm / 10; nd[0] = mm % 10;
            for (int i = 0; i < 4; i++)
                if (nd[i] != od[i]) begin
                    if (nd[i] == 0) e_ld[i] = 1'b1;
                    else            e_inc[i] = 1'b1;
                end
        end
    end

    function automatic int exp_blank(input int md, input bit bl);
`ifdef SET_BLINK_EN
        return (bl && md != 0) ? (1 << (4 - md)) : 0;
`else
        return 0;
`endif
    endfunction

    always @(negedge Clk) begin
        if (!Clr) begin
            check("inc", Inc, e_inc);
            check("ld", Ld, e_ld);
            check("mode", Mode, m_mode);
            check("blank", Blank, exp_blank(m_mode, m_blink));
            check("both_strobes", int'(Inc & Ld), 0);
            if (e_inc == 0 && e_ld == 0 && !load_en)
                check("digits", {bHT, bHU, bMT, bMU}, {2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10)});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic step(input logic t_, input logic m_, input logic i_);
        @(negedge Clk);
        Tick = t_; BtnMode = m_; BtnInc = i_;
        @(negedge Clk);
        Tick = 1'b0; BtnMode = 1'b0; BtnInc = 1'b0;
    endtask

    task automatic load(input int a, input int b, input int c, input int d);
        @(negedge Clk);
        ld_ht = a; ld_hu = b; ld_mt = c; ld_mu = d; load_en = 1'b1;
        @(negedge Clk);
        load_en = 1'b0;
        idle(1);
    endtask

    initial begin
        #1 Clr = 1'b1;
        idle(2);
        check("rst_mode", Mode, 0);
        check("rst_inc", Inc, 0);
        check("rst_ld", Ld, 0);
        check("rst_blank", Blank, 0);
        Clr = 1'b0;

        // 12:34, four ticks -> single MU increment
        load(1, 2, 3, 4);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0); check("tick_no_inc", Inc, 0); idle(3);
        end
        step(1, 0, 0);
        check("min_inc", Inc, 4'b0001);
        check("min_ld", Ld, 4'b0000);
        idle(3);
        check("t1235_mu", bMU, 5);

        // 23:59 -> 00:00
        load(2, 3, 5, 9);
        for (int i = 0; i < 3; i++) begin step(1, 0, 0); idle(3); end
        step(1, 0, 0);
        check("day_ld", Ld, 4'b1111);
        check("day_inc", Inc, 4'b0000);
        idle(1);
        check("day_digits", {bHT, bHU, bMT, bMU}, 0);
        idle(2);

        // 09:59 -> 10:00
        load(0, 9, 5, 9);
        for (int i = 0; i < 3; i++) begin step(1, 0, 0); idle(3); end
        step(1, 0, 0);
        check("h10_ld", Ld, 4'b0111);
        check("h10_inc", Inc, 4'b1000);
        idle(1);
        check("h10_digits", {bHT, bHU, bMT, bMU}, {2'd1, 4'd0, 3'd0, 4'd0});
        idle(2);

        // SET_HU with 23 wraps to 20; Tick in SET is inert
        load(2, 3, 1, 5);
        step(0, 1, 0); idle(3);
        step(0, 1, 0); check("mode_hu", Mode, 2); idle(3);
        step(0, 0, 1); check("hu_wrap_ld", Ld, 4'b0100); check("hu_wrap_inc", Inc, 0); idle(3);
        step(1, 0, 0); check("set_tick_inc", Inc, 0); check("set_tick_ld", Ld, 0); idle(3);

        // back round to SET_HT, then 17 -> 27 -> leave SET_HT clamps to 20
        for (int i = 0; i < 4; i++) begin step(0, 1, 0); idle(3); end
        check("mode_ht", Mode, 1);
        load(1, 7, 4, 2);
        step(0, 0, 1); check("ht_inc", Inc, 4'b1000); idle(3);
        step(0, 1, 0); check("ht_leave_ld", Ld, 4'b0100); check("ht_leave_mode", Mode, 2);
        idle(1);
        check("ht_leave_hu", bHU, 0);
        idle(2);

        // SET_MT: blink on ticks, MT 4 -> 5 -> 0
        step(0, 1, 0); idle(3);
        step(1, 0, 0);
`ifdef SET_BLINK_EN
        check("blink_on", Blank, 4'b0010);
`else
        check("blink_off_build", Blank, 4'b0000);
`endif
        idle(3);
        step(1, 0, 0); check("blink_second", Blank, 4'b0000); idle(3);
        step(0, 0, 1); check("mt_inc", Inc, 4'b0010); idle(3);
        step(0, 0, 1); check("mt_wrap", Ld, 4'b0010); idle(3);

        // SET_MU: BtnMode beats BtnInc
        step(0, 1, 0); idle(3);
        step(0, 1, 1);
        check("mode_wins", Mode, 0);
        check("mode_wins_inc", Inc, 0);
        idle(3);

        // Tick with BtnMode out of RUN is ignored; then Clr mid-set
        step(1, 1, 0); check("tick_mode", Mode, 1); idle(3);
        step(0, 1, 0); idle(3);
        step(0, 1, 0); check("mode_mt", Mode, 3); idle(2);
        #2 Clr = 1'b1;
        #1;
        check("clr_mode", Mode, 0);
        check("clr_inc", Inc, 0);
        check("clr_ld", Ld, 0);
        check("clr_blank", Blank, 0);
        @(negedge Clk);
        Clr = 1'b0;
        idle(2);

        // sc restarted from zero after Clr
        for (int i = 0; i < 4; i++) begin step(1, 0, 0); idle(3); end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
